// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// The NOP is ADDI x0,x0,0, used to fill decode with a bubble.
package instr_fetch_stage_pkg;

    typedef enum logic {
        IF_BOOT = 1'b0,
        IF_RUN  = 1'b1
    } if_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_stage_npc_gen.sv
// Next-PC selection for the fetch stage: boot hold, redirect, stall hold, or sequential.
module npc_gen
    import instr_fetch_stage_pkg::*;
(
    input  logic        State,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    input  logic        StallF,
    input  logic [31:0] PcF,
    output logic [31:0] NextPc
);

    // Redirect target low bits are dropped by word_align.
    logic unused_rpc_lsbs;
    assign unused_rpc_lsbs = ^RedirectPc[1:0];

    always_comb begin
        NextPc = PcF + 32'd4;
        if (State == IF_BOOT) begin
            NextPc = PcF;
        end else if (Redirect) begin
            NextPc = word_align(RedirectPc);
        end else if (StallF) begin
            NextPc = PcF;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, boot FSM, synchronous-read BRAM addressing and the IF/ID register.
// The BRAM address comes from NextPc so the read data always lines up with PcF one edge later.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ImemEn,
    output logic [IMEM_AW-1:0] ImemAddr,
    input  logic [31:0]        ImemRdata,
    input  logic               StallF,
    input  logic               FlushD,
    input  logic               Redirect,
    input  logic [31:0]        RedirectPc,
    output logic [31:0]        PcF,
    output logic [31:0]        PcD,
    output logic [31:0]        IrD,
    output logic               ValidD,
    output logic [31:0]        FetchCnt
);

    if_state_e   state_q, state_d;
    logic        valid_f;
    logic [31:0] next_pc;
    logic [31:0] pc_f_q;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] ir_d_q, ir_d_d;
    logic        valid_d_q, valid_d_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // BOOT lasts exactly one edge: the BRAM needs one read before RESET_PC data exists.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_BOOT: state_d = IF_RUN;
            IF_RUN:  state_d = IF_RUN;
            default: state_d = IF_BOOT;
        endcase
    end

    always_comb begin
        valid_f = (state_q == IF_RUN);
    end

    npc_gen u_npc_gen (
        .State      (state_q),
        .Redirect   (Redirect),
        .RedirectPc (RedirectPc),
        .StallF     (StallF),
        .PcF        (pc_f_q),
        .NextPc     (next_pc)
    );

    assign ImemEn   = rst_n;
    assign ImemAddr = next_pc[IMEM_AW+1:2];

    // A redirect squashes the instruction on ImemRdata even without FlushD.
    always_comb begin
        pc_d_d      = pc_d_q;
        ir_d_d      = ir_d_q;
        valid_d_d   = valid_d_q;
        fetch_cnt_d = fetch_cnt_q;
        if (Redirect || FlushD || !valid_f) begin
            pc_d_d    = pc_f_q;
            ir_d_d    = NOP_INSTR;
            valid_d_d = 1'b0;
        end else if (!StallF) begin
            pc_d_d      = pc_f_q;
            ir_d_d      = ImemRdata;
            valid_d_d   = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q      <= RESET_PC;
            pc_d_q      <= 32'h0000_0000;
            ir_d_q      <= NOP_INSTR;
            valid_d_q   <= 1'b0;
            fetch_cnt_q <= 32'h0000_0000;
        end else begin
            pc_f_q      <= next_pc;
            pc_d_q      <= pc_d_d;
            ir_d_q      <= ir_d_d;
            valid_d_q   <= valid_d_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign PcF      = pc_f_q;
    assign PcD      = pc_d_q;
    assign IrD      = ir_d_q;
    assign ValidD   = valid_d_q;
    assign FetchCnt = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed plus randomized bench for instr_fetch_stage against a program-order fetch model.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ImemEn;
    logic [11:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        StallF, FlushD, Redirect;
    logic [31:0] RedirectPc;
    logic [31:0] PcF, PcD, IrD, FetchCnt;
    logic        ValidD;

    logic [31:0] mem [0:4095];

    int n_asserts = 0;
    int n_fail    = 0;

    // Program-order model of the stage.
    logic        m_run;
    logic [31:0] m_pcf, m_pcd, m_ird, m_cnt;
    logic        m_vd;

    instr_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ImemEn     (ImemEn),
        .ImemAddr   (ImemAddr),
        .ImemRdata  (ImemRdata),
        .StallF     (StallF),
        .FlushD     (FlushD),
        .Redirect   (Redirect),
        .RedirectPc (RedirectPc),
        .PcF        (PcF),
        .PcD        (PcD),
        .IrD        (IrD),
        .ValidD     (ValidD),
        .FetchCnt   (FetchCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ImemEn) ImemRdata <= mem[ImemAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic st, input logic rd, input logic [31:0] rpc);
        if (!m_run) return m_pcf;
        if (rd) return {rpc[31:2], 2'b00};
        if (st) return m_pcf;
        return m_pcf + 32'd4;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pcf = 32'h0; m_pcd = 32'h0; m_ird = NOP; m_vd = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_ImemEn"}, {31'h0, ImemEn}, 32'h0);
        chk({pfx, "_ImemAddr"}, {20'h0, ImemAddr}, 32'h0);
        chk({pfx, "_PcF"}, PcF, 32'h0);
        chk({pfx, "_PcD"}, PcD, 32'h0);
        chk({pfx, "_IrD"}, IrD, NOP);
        chk({pfx, "_ValidD"}, {31'h0, ValidD}, 32'h0);
        chk({pfx, "_FetchCnt"}, FetchCnt, 32'h0);
    endtask

    // One clock edge with the given controls; model advances and all outputs are compared.
    task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        logic [31:0] npc, instr, exp_addr;
        StallF = st; FlushD = fl; Redirect = rd; RedirectPc = rpc;
        @(posedge clk);
        npc   = model_npc(st, rd, rpc);
        instr = mem[m_pcf[13:2]];
        if (rd || fl || !m_run) begin
            m_ird = NOP; m_vd = 1'b0; m_pcd = m_pcf;
        end else if (!st) begin
            m_ird = instr; m_vd = 1'b1; m_pcd = m_pcf; m_cnt = m_cnt + 32'd1;
        end
        m_pcf = npc;
        m_run = 1'b1;
        @(negedge clk);
        exp_addr = model_npc(st, rd, rpc);
        chk("PcF", PcF, m_pcf);
        chk("PcD", PcD, m_pcd);
        chk("IrD", IrD, m_ird);
        chk("ValidD", {31'h0, ValidD}, {31'h0, m_vd});
        chk("FetchCnt", FetchCnt, m_cnt);
        chk("ImemAddr", {20'h0, ImemAddr}, {20'h0, exp_addr[13:2]});
        chk("ImemEn", {31'h0, ImemEn}, 32'h1);
    endtask

    initial begin
        logic [31:0] saved_ir, saved_pd, saved_cnt;
        logic        st, fl, rd;
        int          guard;

        rst_n = 1'b0; StallF = 1'b0; FlushD = 1'b0; Redirect = 1'b0; RedirectPc = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_values("rst");

        // Reset release and 2-edge fetch latency.
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("e1_PcF", PcF, 32'h0);
        chk("e1_ValidD", {31'h0, ValidD}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("e2_IrD", IrD, 32'h0050_0093);
        chk("e2_PcD", PcD, 32'h0);
        chk("e2_ValidD", {31'h0, ValidD}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("e3_IrD", IrD, 32'h0010_0113);
        chk("e3_PcD", PcD, 32'h4);

        // Three-cycle stall while PcF = 8.
        chk("stall_PcF0", PcF, 32'h8);
        saved_ir = IrD; saved_pd = PcD;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, $urandom);
            chk("stall_addr", {20'h0, ImemAddr}, 32'h2);
            chk("stall_IrD", IrD, saved_ir);
            chk("stall_PcD", PcD, saved_pd);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_stall_PcD0", PcD, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_stall_PcD1", PcD, 32'hC);

        // Straight line to the 8th load.
        guard = 0;
        while (m_cnt != 32'd8 && guard < 20) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            guard++;
        end
        chk("line_FetchCnt", FetchCnt, 32'd8);
        chk("line_PcD", PcD, 32'd28);

        // Redirect, stall and flush together.
        saved_cnt = FetchCnt;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        chk("all3_PcF", PcF, 32'h200);
        chk("all3_ValidD", {31'h0, ValidD}, 32'h0);
        chk("all3_FetchCnt", FetchCnt, saved_cnt);

        // Randomized control traffic.
        for (int k = 0; k < 300; k++) begin
            st = ($urandom_range(3) == 0);
            fl = ($urandom_range(7) == 0);
            rd = ($urandom_range(7) == 0);
            step(st, fl, rd, $urandom);
        end

        // Redirect to 0x102 while PcF = 16.
        step(1'b0, 1'b0, 1'b1, 32'h10);
        chk("pre_redir_PcF", PcF, 32'h10);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0102);
        chk("redir_PcF", PcF, 32'h100);
        chk("redir_ValidD", {31'h0, ValidD}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_IrD", IrD, mem[64]);
        chk("redir_PcD", PcD, 32'h100);

        // Asynchronous reset mid-stream at PcF = 0x40.
        step(1'b0, 1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_arst_PcF", PcF, 32'h44);
        step(1'b0, 1'b0, 1'b1, 32'h40);
        chk("arst_at_PcF", PcF, 32'h40);
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge clk);
        check_reset_values("arst_held");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("arst_e1_ValidD", {31'h0, ValidD}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("arst_e2_IrD", IrD, 32'h0050_0093);
        chk("arst_e2_ValidD", {31'h0, ValidD}, 32'h1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage of the pipelined RV32I core. It holds the PC and drives a synchronous-read instruction BRAM (1-cycle read latency). It applies stall and redirect requests from the hazard and branch logic. It registers {PC, instruction, valid} into the IF/ID boundary. Its IrD output feeds the instruction decoder directly: Op = IrD[6:0], Fn3 = IrD[14:12], Fn7 = IrD[31:25], In = IrD[31:7].

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMEM_AW, 12, instruction BRAM word-address width.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ImemEn  out  1  BRAM read enable; 0 while rst_n low, else 1.
- ImemAddr  out  IMEM_AW  BRAM word address, equal to NextPc[IMEM_AW+1:2].
- ImemRdata  in  32  BRAM data for the address presented on the previous edge.
- StallF  in  1  hold PcF and the IF/ID register (load-use hazard).
- FlushD  in  1  replace the IF/ID contents with a bubble.
- Redirect  in  1  taken branch/JAL/JALR resolved in EX.
- RedirectPc  in  32  target of the redirect; bits [1:0] are ignored and forced to 0.
- PcF  out  32  PC of the instruction currently on ImemRdata.
- PcD  out  32  PC of the instruction in decode.
- IrD  out  32  instruction in decode.
- ValidD  out  1  IrD is a real instruction, not a bubble.
- FetchCnt  out  32  count of instructions loaded into D with ValidD=1.

## Operation
- State machine with two states, BOOT and RUN.
  - Reset places the FSM in BOOT.
  - BOOT → RUN on the first edge after reset release, unconditionally.
  - BOOT is needed because the BRAM holds no valid data for RESET_PC until one read edge has occurred.
- ValidF = (state == RUN).
- NextPc priority, first match wins:
  1. BOOT: PcF.
  2. Redirect: {RedirectPc[31:2], 2'b00}.
  3. StallF: PcF.
  4. Otherwise: PcF + 4, mod 2^32.
- PcF ← NextPc every edge. Because ImemAddr is derived from NextPc, ImemRdata always belongs to PcF in the following cycle.
- IF/ID update priority, first match wins:
  1. Redirect or FlushD or !ValidF: bubble. IrD ← NOP_INSTR (32'h0000_0013), ValidD ← 0, PcD ← PcF.
  2. StallF: hold IrD, PcD and ValidD.
  3. Otherwise: IrD ← ImemRdata, PcD ← PcF, ValidD ← 1.
- Redirect squashes both the F-stage instruction and the D-stage instruction, even when FlushD is low.
- FetchCnt increments by 1 on each edge where IF/ID rule 3 applies. It wraps at 2^32.
- StallF together with Redirect: the redirect is taken and the stall is ignored for this stage.
- StallF together with FlushD (no Redirect): PcF holds and D becomes a bubble.

## Timing
- Reset values:
  - state = BOOT; PcF = RESET_PC.
  - PcD = 0; IrD = 32'h0000_0013; ValidD = 0; FetchCnt = 0.
  - ImemEn = 0; ImemAddr = RESET_PC[IMEM_AW+1:2].
- Reset is asynchronous: rst_n falling mid-operation returns every register to its reset value immediately, with no clock required.
- Reset release is at edge 0.
  - Edge 1: RUN, PcF = RESET_PC.
  - Edge 2: ValidD = 1, IrD = mem[RESET_PC].
- Steady state: one instruction enters D per cycle. Latency from NextPc to IrD is 2 edges.
- Redirect sampled high at edge N:
  - Edge N: PcF ← target; D ← bubble.
  - Edge N+1: IrD = mem[target].
  - Redirect penalty is 2 bubbles counting the EX-side flush.
- StallF held for k cycles: PcF, IrD and PcD stay constant for k edges, and ImemAddr re-presents PcF each stalled cycle.

## Structure
- Parameters.v gains `NOP_INSTR (32'h0000_0013) and the state encodings `IF_BOOT and `IF_RUN.
- RESET_PC stays a module parameter.
- One combinational sub-module, npc_gen, computes NextPc from state, Redirect, RedirectPc, StallF and PcF.
- PC register, FSM, IF/ID register and FetchCnt all live in instr_fetch_stage.

## Test plan
- Reset release with mem[0]=32'h0050_0093 and mem[4]=32'h0010_0113.
  - Edge 2: IrD=32'h0050_0093, PcD=0, ValidD=1.
  - Edge 3: IrD=32'h0010_0113, PcD=4.
- Straight line of 8 instructions: PcD advances 0, 4, …, 28 and FetchCnt reads 8 after the 8th load.
- StallF high for 3 cycles while PcF=8.
  - ImemAddr stays 2 for 3 cycles and IrD/PcD are unchanged.
  - After release, PcD continues 8, 12.
- Redirect with RedirectPc=32'h0000_0102 while PcF=16.
  - Next edge: PcF=0x100 and ValidD=0.
  - Edge after that: IrD=mem[0x100], PcD=0x100.
- Redirect, StallF and FlushD all high together: the redirect is taken, D is a bubble, and FetchCnt does not increment.
- rst_n pulsed low mid-stream while PcF=0x40.
  - All outputs take their reset values before the next edge.
  - The fetch restarts from RESET_PC with the same 2-edge latency.
